alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one integer ALU between NUM_REQ requesters (e.g. integer pipe, address-gen, branch-compare).
//  Each requester issues {A, B, Control} under a valid/ready handshake; round-robin arbitration picks one per cycle.
//  The ALU result goes into a single-entry output register, tagged with the requester id.
//  Sits between issue logic and the shared ALU instance; ALU ovfl output is left unconnected (not forwarded).
// PARAMETERS
//  NUM_REQ  2                    number of requesters, legal range 2..8
//  DATA_W   `data_size (32)      operand/result width
//  CTRL_W   `alu_control_size(4) ALU opcode width
//  ID_W     $clog2(NUM_REQ)      requester-id width (derived, not overridable)
// PORTS
//  clk        in   1               system clock, all state on rising edge
//  rst        in   1               synchronous, active-high reset
//  req_valid  in   NUM_REQ         per-requester request valid
//  req_ready  out  NUM_REQ         per-requester accept (one-hot or zero)
//  req_a      in   NUM_REQ*DATA_W  operand A, requester i at [i*DATA_W +: DATA_W]
//  req_b      in   NUM_REQ*DATA_W  operand B, same packing
//  req_ctrl   in   NUM_REQ*CTRL_W  ALU opcode, same packing
//  res_valid  out  1               result register holds valid data
//  res_ready  in   1               consumer accepts result
//  res_data   out  DATA_W          registered ALU result
//  res_id     out  ID_W            index of requester that produced res_data
//  busy       out  1               res_valid | (|req_valid)
// BEHAVIOUR
//  Reset: res_valid=0, res_data=0, res_id=0, rr_ptr=0; req_ready=0 while rst=1.
//  can_accept = !res_valid | res_ready.
//  Grant: first i with req_valid[i], searching from rr_ptr upward, modulo NUM_REQ (wrap NUM_REQ-1 -> 0).
//  Grant depends only on req_valid and rr_ptr, never on req_ready.
//  req_ready[i] = grant[i] & can_accept & !rst. At most one bit set.
//  Transfer on req_valid[i] & req_ready[i]: the granted operands drive the ALU combinationally.
//   Next edge: res_data <= ALU Out, res_id <= i, res_valid <= 1.
//  Latency: exactly 1 cycle from accept to res_valid; throughput 1 op/cycle with res_ready held high.
//  rr_ptr <= (i+1) mod NUM_REQ on accept only; unchanged on idle or stall cycles.
//  Stall (res_valid & !res_ready): res_data/res_id/res_valid hold stable; all req_ready=0.
//  Simultaneous drain+accept: new result loads the same edge and res_valid stays 1 (no bubble).
//  Drain without accept: res_valid <= 0; res_data/res_id keep their last value.
//  Requester holds its payload stable while valid & !ready; dropping valid before ready is legal (request withdrawn).
//  Operands pass through unmodified. Shift masking of B[4:0] and LUI immediate placement belong to the decoder.
//   ALU semantics apply: codes 0000 LUI, 0001/0010 add, 0011 xor, 0100 or, 0101 and, 0110 sll,
//   0111 srl, 1000 sra, 1001 sub, 1010 slt, 1011+ sltu.
//  Reset mid-operation: a pending result is discarded (res_valid=0 next edge) and rr_ptr returns to 0.
//  Reset takes priority over any simultaneous accept or drain.
// STRUCTURE
//  Shared package: ALU opcode enum (alu_op_t, values 4'h0..4'hB as above). DATA_W/CTRL_W come from the constants file.
//  Sub-module alu_rr_arbiter: parameter N; inputs valid[N], ptr; output one-hot grant[N] and encoded grant_id. Combinational.
//  Top level: alu_rr_arbiter, operand mux indexed by grant_id, one alu instance, output register, and rr_ptr register.
// TESTING
//  1 Reset, then req0 A=5 B=3 ctrl=0010 -> req_ready=01 that cycle; next cycle res_valid=1, res_data=8, res_id=0.
//  2 Both valid every cycle, res_ready=1; req0 SUB 3-5 and req1 SLT A=FFFFFFFF B=1
//    -> grants alternate 0,1,0,1; results FFFFFFFE (id0) and 00000001 (id1) with no bubbles.
//  3 Result pending, res_ready=0 for 3 cycles -> res_data/res_id stable, req_ready=00.
//    Raise res_ready with req1 valid -> drain and accept on the same edge; res_valid stays 1.
//  4 NUM_REQ=3, rr_ptr=2, all valid -> grant 2, then 0, then 1 (wrap); only req0 valid with ptr=1 -> grant 0.
//  5 res_valid=1 held by res_ready=0, pulse rst one cycle -> res_valid=0, rr_ptr=0, req_ready=0 during the rst cycle.
//  6 Opcode sweep via req1: LUI B=000ABCDE -> ABCDE000; SRA A=80000000 B=4 -> F8000000;
//    SLTU A=FFFFFFFF B=1 -> 0; ctrl=1111 A=1 B=2 -> 1 (default sltu).

Source files
------------

// File: rtl/alu_share_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package   : alu_share_arbiter_pkg                                        |
// | Purpose   : Shared constants and ALU opcode encoding for the shared-ALU  |
// |             arbiter slice.                                               |
// | Contents  : DATA_SIZE, ALU_CONTROL_SIZE, alu_op_t                        |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
package alu_share_arbiter_pkg;

  localparam int DATA_SIZE        = 32;
  localparam int ALU_CONTROL_SIZE = 4;

  // Opcodes 0x1 and 0x2 both add; anything at or above 0xB behaves as sltu.
  typedef enum logic [3:0] {
    ALU_LUI  = 4'h0,
    ALU_ADD  = 4'h1,
    ALU_ADD2 = 4'h2,
    ALU_XOR  = 4'h3,
    ALU_OR   = 4'h4,
    ALU_AND  = 4'h5,
    ALU_SLL  = 4'h6,
    ALU_SRL  = 4'h7,
    ALU_SRA  = 4'h8,
    ALU_SUB  = 4'h9,
    ALU_SLT  = 4'hA,
    ALU_SLTU = 4'hB
  } alu_op_t;

endpackage : alu_share_arbiter_pkg
`default_nettype wire

// File: rtl/alu_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : alu_rr_arbiter                                               |
// | Purpose   : Combinational round-robin grant. Picks the first valid       |
// |             requester at or above ptr, wrapping N-1 -> 0.                |
// | Ports     : valid    in  N     request valid per requester               |
// |             ptr      in  ID_W  highest-priority requester index          |
// |             grant    out N     one-hot grant (zero when nothing valid)   |
// |             grant_id out ID_W  encoded index of the granted requester    |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module alu_rr_arbiter #(
  parameter int N    = 2,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    valid,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id
);

  always_comb begin
    logic found;
    int   idx;
    found    = 1'b0;
    idx      = 0;
    grant    = '0;
    grant_id = '0;
    // Walk N positions starting at ptr; the first valid one wins.
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
      end
    end
  end

endmodule : alu_rr_arbiter
`default_nettype wire

// File: rtl/alu_share_arbiter_alu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : alu_share_arbiter_alu                                        |
// | Purpose   : Combinational integer ALU shared by the requesters.          |
// | Ports     : a    in  DATA_W  operand A                                   |
// |             b    in  DATA_W  operand B (shift amount taken from b[4:0])  |
// |             ctrl in  CTRL_W  opcode (alu_op_t)                           |
// |             out  out DATA_W  result                                      |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module alu_share_arbiter_alu
  import alu_share_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_SIZE,
  parameter int CTRL_W = ALU_CONTROL_SIZE
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] out
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  always_comb begin
    out = '0;
    case (ctrl)
      ALU_LUI:           out = b << 12;
      ALU_ADD, ALU_ADD2: out = a + b;
      ALU_XOR:           out = a ^ b;
      ALU_OR:            out = a | b;
      ALU_AND:           out = a & b;
      ALU_SLL:           out = a << shamt;
      ALU_SRL:           out = a >> shamt;
      ALU_SRA:           out = DATA_W'($signed(a) >>> shamt);
      ALU_SUB:           out = a - b;
      ALU_SLT:           out = DATA_W'($signed(a) < $signed(b));
      default:           out = DATA_W'(a < b);
    endcase
  end

endmodule : alu_share_arbiter_alu
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : alu_share_arbiter                                          |
// | Purpose   : Shares one integer ALU among NUM_REQ requesters with        |
// |             round-robin arbitration and a single-entry tagged result     |
// |             register.                                                    |
// | Ports     : clk, rst                 clock / sync active-high reset      |
// |             req_valid/req_ready      per-requester handshake             |
// |             req_a/req_b/req_ctrl     packed per-requester operands       |
// |             res_valid/res_ready      result handshake                    |
// |             res_data/res_id          registered result and its source    |
// |             busy                     result pending or any request       |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = DATA_SIZE,
  parameter int CTRL_W  = ALU_CONTROL_SIZE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*CTRL_W-1:0] req_ctrl,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [DATA_W-1:0]         res_data,
  output logic [$clog2(NUM_REQ)-1:0] res_id,
  output logic                      busy
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0]    rr_ptr;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               can_accept;
  logic               accept;
  logic [DATA_W-1:0]  sel_a;
  logic [DATA_W-1:0]  sel_b;
  logic [CTRL_W-1:0]  sel_ctrl;
  logic [DATA_W-1:0]  alu_out;
  logic [ID_W-1:0]    ptr_next;

  alu_rr_arbiter #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_arb (
    .valid    (req_valid),
    .ptr      (rr_ptr),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // Grant is computed without reference to ready; ready then gates it so
  // a stalled output or reset never produces a handshake.
  assign can_accept = !res_valid || res_ready;
  assign req_ready  = grant & {NUM_REQ{can_accept && !rst}};
  assign accept     = |req_ready;

  assign sel_a    = req_a[int'(grant_id)*DATA_W +: DATA_W];
  assign sel_b    = req_b[int'(grant_id)*DATA_W +: DATA_W];
  assign sel_ctrl = req_ctrl[int'(grant_id)*CTRL_W +: CTRL_W];

  // The ALU carries no overflow output: overflow is not forwarded here.
  alu_share_arbiter_alu #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_alu (
    .a    (sel_a),
    .b    (sel_b),
    .ctrl (sel_ctrl),
    .out  (alu_out)
  );

  assign ptr_next = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
      rr_ptr    <= '0;
    end else if (accept) begin
      // Covers simultaneous drain: the new result replaces the old one.
      res_valid <= 1'b1;
      res_data  <= alu_out;
      res_id    <= grant_id;
      rr_ptr    <= ptr_next;
    end else if (res_ready) begin
      // Data and id are left as-is so the last result stays observable.
      res_valid <= 1'b0;
    end
  end

  assign busy = res_valid || (|req_valid);

endmodule : alu_share_arbiter
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : tb_alu_share_arbiter                                         |
// | Purpose   : Scoreboard bench for alu_share_arbiter (2- and 3-requester). |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_a, req_b;
  logic [7:0]  req_ctrl;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic [0:0]  res_id;
  logic        busy;

  logic [2:0]  m_valid;
  logic [2:0]  m_ready;
  logic [95:0] m_a, m_b;
  logic [11:0] m_ctrl;
  logic        m_res_valid;
  logic [31:0] m_res_data;
  logic [1:0]  m_res_id;
  logic        m_busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [32:0] exp_q[$];   // {id, data}

  always #5 clk = ~clk;

  alu_share_arbiter #(.NUM_REQ(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_id(res_id), .busy(busy)
  );

  alu_share_arbiter #(.NUM_REQ(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(m_valid), .req_ready(m_ready),
    .req_a(m_a), .req_b(m_b), .req_ctrl(m_ctrl),
    .res_valid(m_res_valid), .res_ready(1'b1), .res_data(m_res_data),
    .res_id(m_res_id), .busy(m_busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    req_ctrl[3:0] = c; req_a[31:0] = a; req_b[31:0] = b;
  endtask

  task automatic set1(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    req_ctrl[7:4] = c; req_a[63:32] = a; req_b[63:32] = b;
  endtask

  // Monitor: every result handed to the consumer is checked against the queue.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got id=%0d data=%h with empty queue", res_id, res_data);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("res_data", 64'(res_data), 64'(e[31:0]));
        chk("res_id", 64'(res_id), 64'(e[32]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Opcode sweep through requester 1: ctrl, A, B, expected.
  logic [3:0]  sw_c [11] = '{4'h0, 4'h8, 4'hB, 4'hF, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h2, 4'hA};
  logic [31:0] sw_a [11] = '{32'h0, 32'h80000000, 32'hFFFFFFFF, 32'h1, 32'hF0F0F0F0, 32'hF0000000,
                             32'hF0F0F0F0, 32'h1, 32'h80000000, 32'h7FFFFFFF, 32'h1};
  logic [31:0] sw_b [11] = '{32'h000ABCDE, 32'h4, 32'h1, 32'h2, 32'hFF00FF00, 32'h0000000F,
                             32'hFF00FF00, 32'h24, 32'h4, 32'h1, 32'hFFFFFFFF};
  logic [31:0] sw_e [11] = '{32'hABCDE000, 32'hF8000000, 32'h0, 32'h1, 32'h0FF00FF0, 32'hF000000F,
                             32'hF000F000, 32'h10, 32'h08000000, 32'h80000000, 32'h0};

  // 3-requester wrap table: valid pattern, expected ready, expected id.
  logic [2:0] w_v  [6] = '{3'b010, 3'b111, 3'b111, 3'b111, 3'b001, 3'b001};
  logic [2:0] w_r  [6] = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b001, 3'b001};
  logic [1:0] w_id [6] = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd0, 2'd0};

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_ctrl = '0; res_ready = 1'b1;
    m_valid = '0; m_a = '0; m_b = '0; m_ctrl = '0;
    step(); step();
    req_valid = 2'b01;
    #1;
    chk("ready_in_reset", 64'(req_ready), 64'd0);
    chk("reset_res_valid", 64'(res_valid), 64'd0);
    chk("reset_res_data", 64'(res_data), 64'd0);
    chk("reset_res_id", 64'(res_id), 64'd0);
    step();

    // Single add from requester 0, one-cycle latency.
    rst = 1'b0;
    set0(4'h2, 32'd5, 32'd3);
    req_valid = 2'b01;
    #1;
    chk("t1_ready", 64'(req_ready), 64'b01);
    exp_q.push_back({1'b0, 32'd8});
    step();
    chk("t1_res_valid", 64'(res_valid), 64'd1);
    chk("t1_res_data", 64'(res_data), 64'd8);

    // Both requesters every cycle; pointer is at 1 after the first accept.
    set0(4'h9, 32'd3, 32'd5);
    set1(4'hA, 32'hFFFFFFFF, 32'd1);
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_ready", 64'(req_ready), (i % 2 == 0) ? 64'b10 : 64'b01);
      exp_q.push_back((i % 2 == 0) ? {1'b1, 32'h1} : {1'b0, 32'hFFFFFFFE});
      step();
      chk("t2_no_bubble", 64'(res_valid), 64'd1);
    end

    // Stall for three cycles with requester 1 waiting.
    res_ready = 1'b0;
    req_valid = 2'b10;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_stall_ready", 64'(req_ready), 64'd0);
      chk("t3_stall_data", 64'(res_data), 64'hFFFFFFFE);
      chk("t3_stall_id", 64'(res_id), 64'd0);
      chk("t3_busy", 64'(busy), 64'd1);
      step();
    end
    res_ready = 1'b1;
    #1;
    chk("t3_drain_accept_ready", 64'(req_ready), 64'b10);
    exp_q.push_back({1'b1, 32'h1});
    step();
    chk("t3_res_valid_held", 64'(res_valid), 64'd1);
    chk("t3_res_id", 64'(res_id), 64'd1);
    req_valid = 2'b00;
    step();
    chk("drain_res_valid", 64'(res_valid), 64'd0);
    chk("drain_keeps_id", 64'(res_id), 64'd1);
    chk("drain_keeps_data", 64'(res_data), 64'd1);
    chk("idle_busy", 64'(busy), 64'd0);

    // Pending result discarded by reset; pointer returns to 0.
    res_ready = 1'b0;
    set0(4'h1, 32'd1, 32'd1);
    req_valid = 2'b01;
    #1;
    chk("t5_ready", 64'(req_ready), 64'b01);
    step();
    req_valid = 2'b00;
    chk("t5_pending", 64'(res_valid), 64'd1);
    step();
    rst = 1'b1;
    req_valid = 2'b11;
    #1;
    chk("t5_ready_in_rst", 64'(req_ready), 64'd0);
    step();
    rst = 1'b0;
    chk("t5_res_valid_cleared", 64'(res_valid), 64'd0);
    chk("t5_res_data_cleared", 64'(res_data), 64'd0);
    res_ready = 1'b1;
    set0(4'h1, 32'd10, 32'd20);
    #1;
    chk("t5_ptr_reset_grant", 64'(req_ready), 64'b01);
    exp_q.push_back({1'b0, 32'd30});
    step();

    // Opcode sweep via requester 1.
    req_valid = 2'b10;
    for (int i = 0; i < 11; i++) begin
      set1(sw_c[i], sw_a[i], sw_b[i]);
      #1;
      chk("t6_ready", 64'(req_ready), 64'b10);
      exp_q.push_back({1'b1, sw_e[i]});
      step();
    end
    req_valid = 2'b00;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    // Three requesters: wrap-around order.
    for (int i = 0; i < 6; i++) begin
      m_valid = w_v[i];
      #1;
      chk("t4_ready", 64'(m_ready), 64'(w_r[i]));
      step();
      chk("t4_res_id", 64'(m_res_id), 64'(w_id[i]));
      chk("t4_res_valid", 64'(m_res_valid), 64'd1);
    end
    m_valid = '0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_alu_share_arbiter
`default_nettype wire
